// File: rtl/apb_master_bridge_if.sv
// Bundles the request/response port and the APB master port of apb_master_bridge.
// The master modport is the bridge's view; the slave modport is the surrounding fabric's view.
interface apb_master_bridge_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
);
    logic                  req_valid_i;
    logic                  req_ready_o;
    logic [ADDR_WIDTH-1:0] req_addr_i;
    logic                  req_write_i;
    logic [DATA_WIDTH-1:0] req_wdata_i;
    logic [STRB_WIDTH-1:0] req_wstrb_i;
    logic [2:0]            req_prot_i;

    logic                  rsp_valid_o;
    logic                  rsp_ready_i;
    logic [DATA_WIDTH-1:0] rsp_rdata_o;
    logic                  rsp_err_o;

    logic [ADDR_WIDTH-1:0] paddr_o;
    logic [2:0]            pprot_o;
    logic                  psel_o;
    logic                  penable_o;
    logic                  pwrite_o;
    logic [DATA_WIDTH-1:0] pwdata_o;
    logic [STRB_WIDTH-1:0] pstrb_o;
    logic                  pready_i;
    logic [DATA_WIDTH-1:0] prdata_i;
    logic                  pslverr_i;

    modport master (
        input  req_valid_i, req_addr_i, req_write_i, req_wdata_i, req_wstrb_i, req_prot_i,
        output req_ready_o,
        output rsp_valid_o, rsp_rdata_o, rsp_err_o,
        input  rsp_ready_i,
        output paddr_o, pprot_o, psel_o, penable_o, pwrite_o, pwdata_o, pstrb_o,
        input  pready_i, prdata_i, pslverr_i
    );

    modport slave (
        output req_valid_i, req_addr_i, req_write_i, req_wdata_i, req_wstrb_i, req_prot_i,
        input  req_ready_o,
        input  rsp_valid_o, rsp_rdata_o, rsp_err_o,
        output rsp_ready_i,
        input  paddr_o, pprot_o, psel_o, penable_o, pwrite_o, pwdata_o, pstrb_o,
        output pready_i, prdata_i, pslverr_i
    );
endinterface

// File: rtl/apb_master_bridge.sv
// Single-outstanding valid/ready request -> APB SETUP+ACCESS transfer -> one response beat.
// Latency: accept edge N, SETUP N+1, ACCESS N+2 (+1 per APB wait), response N+3 (+waits).
// Backpressure: req_ready only in IDLE; response held until rsp_ready. APB_BRIDGE_TIMEOUT_EN adds an ACCESS timeout.
module apb_master_bridge #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int STRB_WIDTH     = DATA_WIDTH / 8,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    apb_master_bridge_if.master bus
);

    if (ADDR_WIDTH < 1) begin : g_bad_addr_width
        $error("apb_master_bridge: ADDR_WIDTH must be >= 1");
    end
    if ((DATA_WIDTH < 8) || (DATA_WIDTH % 8 != 0)) begin : g_bad_data_width
        $error("apb_master_bridge: DATA_WIDTH must be a multiple of 8");
    end
    if (STRB_WIDTH != DATA_WIDTH / 8) begin : g_bad_strb_width
        $error("apb_master_bridge: STRB_WIDTH is derived from DATA_WIDTH");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("apb_master_bridge: TIMEOUT_CYCLES must be >= 1");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic                  cap_en;
    logic                  rsp_load;
    logic [DATA_WIDTH-1:0] rsp_rdata_d;
    logic                  rsp_err_d;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  write_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_WIDTH-1:0] wstrb_q;
    logic [2:0]            prot_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  err_q;

`ifdef APB_BRIDGE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;

    // Cleared in SETUP so it starts at zero on the first ACCESS cycle.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (state_q == SETUP) begin
            cnt_q <= '0;
        end else if ((state_q == ACCESS) && !bus.pready_i) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cap_en      = 1'b0;
        rsp_load    = 1'b0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req_valid_i) begin
                    cap_en  = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (bus.pready_i) begin
                    rsp_load    = 1'b1;
                    rsp_rdata_d = write_q ? '0 : bus.prdata_i;
                    rsp_err_d   = bus.pslverr_i;
                    state_d     = RESP;
                end
`ifdef APB_BRIDGE_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    rsp_load    = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    state_d     = RESP;
                end
`endif
            end
            RESP: begin
                if (bus.rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            wstrb_q <= '0;
            prot_q  <= '0;
        end else if (cap_en) begin
            addr_q  <= bus.req_addr_i;
            write_q <= bus.req_write_i;
            wdata_q <= bus.req_wdata_i;
            wstrb_q <= bus.req_wstrb_i;
            prot_q  <= bus.req_prot_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (rsp_load) begin
            rdata_q <= rsp_rdata_d;
            err_q   <= rsp_err_d;
        end
    end

    // Control outputs decode straight from the state register; payload comes from the capture flops.
    assign bus.req_ready_o = rst_ni && (state_q == IDLE);
    assign bus.psel_o      = (state_q == SETUP) || (state_q == ACCESS);
    assign bus.penable_o   = (state_q == ACCESS);
    assign bus.rsp_valid_o = (state_q == RESP);
    assign bus.rsp_rdata_o = rdata_q;
    assign bus.rsp_err_o   = err_q;
    assign bus.paddr_o     = addr_q;
    assign bus.pwrite_o    = write_q;
    assign bus.pwdata_o    = wdata_q;
    assign bus.pstrb_o     = wstrb_q;
    assign bus.pprot_o     = prot_q;

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- Single-outstanding bridge from a valid/ready register-request port to an APB master port.
- Drives the input side of the APB bus demux; its paddr/psel/penable/pwrite/pwdata/pstrb/pprot feed that demux, which returns pready/prdata/pslverr.
- Converts each accepted request into one APB SETUP+ACCESS transfer and returns a single response beat.

Parameters:
- ADDR_WIDTH, 32, APB and request address width; must be >= 1.
- DATA_WIDTH, 32, data width; multiple of 8, >= 8.
- STRB_WIDTH, DATA_WIDTH/8, derived; do not override.
- TIMEOUT_CYCLES, 256, ACCESS-phase cycle limit; used only with APB_BRIDGE_TIMEOUT_EN; must be >= 1.

Ports:
- clk_i  in  1  clock, all logic on rising edge.
- rst_ni  in  1  reset: synchronous, active-low.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request accepted when valid&ready.
- req_addr_i  in  ADDR_WIDTH  byte address.
- req_write_i  in  1  1=write, 0=read.
- req_wdata_i  in  DATA_WIDTH  write data.
- req_wstrb_i  in  STRB_WIDTH  write byte strobes.
- req_prot_i  in  3  APB protection attributes.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response consumed when valid&ready.
- rsp_rdata_o  out  DATA_WIDTH  read data; 0 for writes.
- rsp_err_o  out  1  slave error or timeout.
- paddr_o  out  ADDR_WIDTH  APB address.
- pprot_o  out  3  APB prot.
- psel_o  out  1  APB select.
- penable_o  out  1  APB enable.
- pwrite_o  out  1  APB direction.
- pwdata_o  out  DATA_WIDTH  APB write data.
- pstrb_o  out  STRB_WIDTH  APB strobes.
- pready_i  in  1  APB ready.
- prdata_i  in  DATA_WIDTH  APB read data.
- pslverr_i  in  1  APB slave error.

Behaviour:
- FSM states: IDLE, SETUP, ACCESS, RESP. Reset state IDLE.
- Reset (rst_ni=0 at a clock edge): state<=IDLE; all registered outputs, request capture registers, response registers and timeout counter <=0. req_ready_o is forced 0 while rst_ni=0.
- IDLE: req_ready_o=1, psel_o=0, penable_o=0, rsp_valid_o=0. On req_valid_i: capture addr/write/wdata/wstrb/prot and go to SETUP.
- SETUP (exactly 1 cycle): psel_o=1, penable_o=0, paddr/pwrite/pwdata/pstrb/pprot driven from the capture registers. Next state ACCESS.
- ACCESS: psel_o=1, penable_o=1, payload held stable. pready_i=1 at an edge -> go to RESP and latch results:
  - reads: rsp_rdata_o<=prdata_i.
  - writes: rsp_rdata_o<=0.
  - rsp_err_o<=pslverr_i.
- pready_i=0 in ACCESS: remain in ACCESS, all APB outputs unchanged.
- RESP: psel_o=0, penable_o=0, rsp_valid_o=1; rsp_rdata_o/rsp_err_o stable. rsp_ready_i=1 -> IDLE.
- Backpressure: rsp_valid_o never drops before the handshake. req_ready_o=0 in every state except IDLE.
- Latency: handshake at edge N -> SETUP in cycle N+1 -> ACCESS in N+2. With zero-wait pready, rsp_valid_o rises in cycle N+3. Each APB wait cycle adds 1. Minimum request-to-request spacing is 4 cycles.
- paddr_o/pwdata_o/pstrb_o are don't-care while psel_o=0; they hold the last captured values.
- pslverr_i and prdata_i are sampled only in ACCESS when pready_i=1; ignored at all other times.
- No address arithmetic: paddr_o equals req_addr_i unmodified.
- Reset mid-transfer: next edge forces IDLE with psel_o=0 and drops any pending response. No response is ever issued for the aborted request.

Optional Feature:
- Macro: APB_BRIDGE_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to ACCESS and increments each ACCESS cycle with pready_i=0.
  - If it reaches TIMEOUT_CYCLES with pready_i still 0, the FSM goes to RESP with rsp_err_o=1 and rsp_rdata_o=0, deasserting psel_o/penable_o.
  - pready_i=1 in that same cycle takes precedence (normal completion).
  - The counter width is $clog2(TIMEOUT_CYCLES+1).
- Undefined: no counter exists; ACCESS waits for pready_i indefinitely.

Test Plan:
- Zero-wait read: req addr=0x100, write=0; slave pready=1, prdata=0xDEADBEEF at first ACCESS -> psel high cycles N+1..N+2, penable only N+2; rsp_valid at N+3, rdata=0xDEADBEEF, err=0.
- Write with 3 wait states: addr=0x204, wdata=0x12345678, wstrb=0xF; pready low 3 ACCESS cycles -> pwdata/paddr/pstrb stable for 4 ACCESS cycles; rsp at N+6, rdata=0, err=0.
- Slave error: read to addr=0xFFFF0000 with decoder returning pready=1, pslverr=1 -> rsp err=1, rdata=0 (decoder value).
- Response backpressure: rsp_ready_i=0 for 5 cycles -> rsp_valid_o, rdata and err held; req_ready_o=0 throughout; a queued req_valid_i is accepted only after the response handshake.
- Reset mid-ACCESS: assert rst_ni=0 for 1 cycle during ACCESS -> psel_o=0 and penable_o=0 next cycle, no rsp_valid_o, req_ready_o=1 after release.
- With APB_BRIDGE_TIMEOUT_EN and TIMEOUT_CYCLES=4, pready held 0 -> after 4 ACCESS cycles psel drops, rsp err=1, rdata=0. Repeat with pready=1 on cycle 4 -> normal response, err=0.
